// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with latched pedestrian WALK phase and tick-timed phases.
// Optional night flashing mode is compiled in with TRAFFIC_NIGHT_FLASH_EN.
module traffic_light_ctrl #(
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 4,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic night,
`endif
  output logic ns_g,
  output logic ns_y,
  output logic ns_r,
  output logic ew_g,
  output logic ew_y,
  output logic ew_r,
  output logic walk,
  output logic ped_wait
);

  typedef enum logic [2:0] {
    S_NS_G = 3'd0,
    S_NS_Y = 3'd1,
    S_AR1  = 3'd2,
    S_EW_G = 3'd3,
    S_EW_Y = 3'd4,
    S_AR2  = 3'd5,
    S_WALK = 3'd6
`ifdef TRAFFIC_NIGHT_FLASH_EN
    , S_FLASH = 3'd7
`endif
  } state_t;

  localparam bit              SKIP_AR = (ALLRED_TICKS == 0);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(SKIP_AR ? 0 : ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WALK_TICKS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ped_wait;
  logic             r_flash;

  state_t           w_next;
  state_t           w_after_ew;
  logic [CNT_W-1:0] w_last;
  logic             w_done;
  logic             w_in_flash;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_last     = '0;
    w_in_flash = 1'b0;
    w_next     = r_state;
    w_after_ew = r_ped_wait ? S_WALK : S_NS_G;

    case (r_state)
      S_NS_G, S_EW_G: w_last = G_LAST;
      S_NS_Y, S_EW_Y: w_last = Y_LAST;
      S_AR1,  S_AR2:  w_last = A_LAST;
      S_WALK:         w_last = W_LAST;
      default:        w_last = '0;
    endcase
    w_done = tick && (r_cnt == w_last);

    case (r_state)
      S_NS_G: if (w_done) w_next = S_NS_Y;
      S_NS_Y: if (w_done) w_next = SKIP_AR ? S_EW_G : S_AR1;
      S_AR1:  if (w_done) w_next = S_EW_G;
      S_EW_G: if (w_done) w_next = S_EW_Y;
      S_EW_Y: if (w_done) w_next = SKIP_AR ? w_after_ew : S_AR2;
      S_AR2:  if (w_done) w_next = w_after_ew;
      S_WALK: if (w_done) w_next = S_NS_G;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      S_FLASH: begin
        w_in_flash = 1'b1;
        if (tick && !night) w_next = SKIP_AR ? w_after_ew : S_AR2;
      end
`endif
      default: w_next = S_NS_G;
    endcase

`ifdef TRAFFIC_NIGHT_FLASH_EN
    // Night mode diverts only at the end of a yellow phase.
    if (w_done && night && (r_state == S_NS_Y || r_state == S_EW_Y))
      w_next = S_FLASH;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_NS_G;
      r_cnt      <= '0;
      r_ped_wait <= 1'b0;
      r_flash    <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_next != r_state)
        r_cnt <= '0;
      else if (tick && !w_in_flash)
        r_cnt <= r_cnt + 1'b1;

      // Entering WALK serves the request; a press on that same edge is dropped.
      if (w_next == S_WALK && r_state != S_WALK)
        r_ped_wait <= 1'b0;
      else if (ped_req && r_state != S_WALK)
        r_ped_wait <= 1'b1;

      if (w_in_flash && w_next == r_state)
        r_flash <= tick ? ~r_flash : r_flash;
      else
        r_flash <= 1'b1;
    end
  end

  always_comb begin
    ns_g     = 1'b0;
    ns_y     = 1'b0;
    ns_r     = 1'b0;
    ew_g     = 1'b0;
    ew_y     = 1'b0;
    ew_r     = 1'b0;
    walk     = 1'b0;
    ped_wait = r_ped_wait;
    case (r_state)
      S_NS_G: begin ns_g = 1'b1; ew_r = 1'b1; end
      S_NS_Y: begin ns_y = 1'b1; ew_r = 1'b1; end
      S_EW_G: begin ew_g = 1'b1; ns_r = 1'b1; end
      S_EW_Y: begin ew_y = 1'b1; ns_r = 1'b1; end
      S_WALK: begin ns_r = 1'b1; ew_r = 1'b1; walk = 1'b1; end
`ifdef TRAFFIC_NIGHT_FLASH_EN
      S_FLASH: begin ns_y = r_flash; ew_r = r_flash; end
`endif
      default: begin ns_r = 1'b1; ew_r = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: table-driven phase sequences plus hand-written corner cases.
// Night-flash sequence is exercised only when TRAFFIC_NIGHT_FLASH_EN is defined.
module tb_traffic_light_ctrl;

  localparam logic [6:0] L_NSG  = 7'b1000010;
  localparam logic [6:0] L_NSY  = 7'b0100010;
  localparam logic [6:0] L_AR   = 7'b0010010;
  localparam logic [6:0] L_EWG  = 7'b0011000;
  localparam logic [6:0] L_EWY  = 7'b0010100;
  localparam logic [6:0] L_WALK = 7'b0010011;
  localparam logic [6:0] L_DARK = 7'b0000000;

  typedef struct {
    logic       ped;
    logic [6:0] lamps;
    logic       pw;
  } vec_t;

  logic clk = 1'b0;
  logic rst, tick, ped_req, tick2, ped2;
  logic night, night2;
  logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_wait;
  logic ns_g2, ns_y2, ns_r2, ew_g2, ew_y2, ew_r2, walk2, ped_wait2;
  logic [6:0] lamps, lamps2;

  int n_checks = 0;
  int n_pass   = 0;
  int onehot_err = 0;
  int ar_seen    = 0;
  bit started = 1'b0;
  bit in_flash = 1'b0;

  vec_t t1[16];
  vec_t t2[20];

  always #5 clk = ~clk;

  assign lamps  = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};
  assign lamps2 = {ns_g2, ns_y2, ns_r2, ew_g2, ew_y2, ew_r2, walk2};

  traffic_light_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night(night),
`endif
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .walk(walk), .ped_wait(ped_wait)
  );

  traffic_light_ctrl #(.GREEN_TICKS(1), .YELLOW_TICKS(1), .ALLRED_TICKS(0)) dut2 (
    .clk(clk), .rst(rst), .tick(tick2), .ped_req(ped2),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night(night2),
`endif
    .ns_g(ns_g2), .ns_y(ns_y2), .ns_r(ns_r2), .ew_g(ew_g2), .ew_y(ew_y2), .ew_r(ew_r2),
    .walk(walk2), .ped_wait(ped_wait2)
  );

  // Per-cycle lamp sanity: one lamp per road, never conflicting proceed aspects.
  always @(negedge clk) begin
    if (started && !rst) begin
      if (!in_flash) begin
        if (!$onehot({ns_g, ns_y, ns_r}) || !$onehot({ew_g, ew_y, ew_r})) onehot_err++;
        if ((ns_g || ns_y) && (ew_g || ew_y)) onehot_err++;
      end
      if (ns_r2 && ew_r2 && !walk2) ar_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // One tick period of 10 cycles on dut; optional 1-cycle ped_req pulse at its start.
  task automatic tick_once(input logic ped);
    if (ped) begin
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      check("ped_latch", {31'd0, ped_wait}, 32'd1);
      cycles(8);
    end else begin
      cycles(9);
    end
    pulse_tick();
  endtask

  task automatic tick2_once();
    cycles(9);
    tick2 = 1'b1;
    @(negedge clk);
    tick2 = 1'b0;
  endtask

  task automatic check_dut(input string name, input logic [6:0] exp_l, input logic exp_pw);
    check({name, "_lamps"}, {25'd0, lamps}, {25'd0, exp_l});
    check({name, "_pw"}, {31'd0, ped_wait}, {31'd0, exp_pw});
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; ped_req = 1'b0; tick2 = 1'b0; ped2 = 1'b0;
    night = 1'b0; night2 = 1'b0;

    t1 = '{'{0,L_NSG,0}, '{0,L_NSG,0}, '{0,L_NSG,0}, '{0,L_NSG,0}, '{0,L_NSY,0},
           '{0,L_NSY,0}, '{0,L_AR,0},  '{0,L_EWG,0}, '{0,L_EWG,0}, '{0,L_EWG,0},
           '{0,L_EWG,0}, '{0,L_EWG,0}, '{0,L_EWY,0}, '{0,L_EWY,0}, '{0,L_AR,0},
           '{0,L_NSG,0}};
    t2 = '{'{0,L_NSG,0}, '{0,L_NSG,0}, '{0,L_NSG,0}, '{0,L_NSG,0}, '{0,L_NSY,0},
           '{0,L_NSY,0}, '{0,L_AR,0},  '{0,L_EWG,0}, '{0,L_EWG,0}, '{1,L_EWG,1},
           '{0,L_EWG,1}, '{0,L_EWG,1}, '{0,L_EWY,1}, '{0,L_EWY,1}, '{0,L_AR,1},
           '{0,L_WALK,0},'{0,L_WALK,0},'{0,L_WALK,0},'{0,L_WALK,0},'{0,L_NSG,0}};

    cycles(3);
    rst = 1'b0;
    started = 1'b1;
    check_dut("reset", L_NSG, 1'b0);

    // Plain 16-tick cycle, then a 20-tick cycle with a request raised in EW_G.
    for (int i = 0; i < 16; i++) begin
      tick_once(t1[i].ped);
      check_dut($sformatf("t1_v%0d", i + 1), t1[i].lamps, t1[i].pw);
    end
    for (int i = 0; i < 20; i++) begin
      tick_once(t2[i].ped);
      check_dut($sformatf("t2_v%0d", i + 1), t2[i].lamps, t2[i].pw);
    end

    // Request in NS_G, then ped_req held high from WALK entry through WALK exit.
    tick_once(1'b1);
    repeat (14) tick_once(1'b0);
    check_dut("t3_ar2", L_AR, 1'b1);
    cycles(9);
    ped_req = 1'b1;
    pulse_tick();
    check_dut("t3_walk_entry", L_WALK, 1'b0);
    repeat (3) begin
      cycles(9);
      pulse_tick();
    end
    check_dut("t3_walk_held", L_WALK, 1'b0);
    cycles(9);
    pulse_tick();
    ped_req = 1'b0;
    check_dut("t3_walk_exit", L_NSG, 1'b0);
    repeat (15) tick_once(1'b0);
    check_dut("t3_ar2_nowait", L_AR, 1'b0);
    tick_once(1'b0);
    check_dut("t3_no_second_walk", L_NSG, 1'b0);

    // Short-phase instance with all-red skipped.
    tick2_once(); check("t4_1", {25'd0, lamps2}, {25'd0, L_NSY});
    tick2_once(); check("t4_2", {25'd0, lamps2}, {25'd0, L_EWG});
    tick2_once(); check("t4_3", {25'd0, lamps2}, {25'd0, L_EWY});
    tick2_once(); check("t4_4", {25'd0, lamps2}, {25'd0, L_NSG});
    ped2 = 1'b1;
    @(negedge clk);
    ped2 = 1'b0;
    check("t4_pw", {31'd0, ped_wait2}, 32'd1);
    repeat (4) tick2_once();
    check("t4_walk", {25'd0, lamps2}, {25'd0, L_WALK});
    check("t4_walk_pw", {31'd0, ped_wait2}, 32'd0);
    repeat (4) tick2_once();
    check("t4_after_walk", {25'd0, lamps2}, {25'd0, L_NSG});

    // Reset mid EW_Y with a pending request; coincident tick must not count.
    tick_once(1'b1);
    repeat (12) tick_once(1'b0);
    check_dut("t5_ewy", L_EWY, 1'b1);
    cycles(5);
    rst = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick = 1'b0;
    check_dut("t5_after_rst", L_NSG, 1'b0);
    repeat (4) tick_once(1'b0);
    check_dut("t5_cnt0_hold", L_NSG, 1'b0);
    tick_once(1'b0);
    check_dut("t5_cnt0_next", L_NSY, 1'b0);

`ifdef TRAFFIC_NIGHT_FLASH_EN
    // dut sits in NS_Y with cnt=0; night diverts at its terminating tick.
    night = 1'b1;
    tick_once(1'b0);
    check_dut("t6_nsy", L_NSY, 1'b0);
    in_flash = 1'b1;
    tick_once(1'b0);
    check_dut("t6_flash_on", L_NSY, 1'b0);
    tick_once(1'b0);
    check_dut("t6_flash_off", L_DARK, 1'b0);
    tick_once(1'b0);
    check_dut("t6_flash_on2", L_NSY, 1'b0);
    night = 1'b0;
    tick_once(1'b0);
    in_flash = 1'b0;
    check_dut("t6_ar2", L_AR, 1'b0);
    tick_once(1'b0);
    check_dut("t6_nsg", L_NSG, 1'b0);
`endif

    check("lamp_onehot_errors", onehot_err, 32'd0);
    check("dut2_allred_seen", ar_seen, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
